vector_ldst_sequencer: RTL and testbench
========================================

// Module: vector_ldst_sequencer
// PURPOSE
// Parametrised vector/scalar load-store sequencer in the MEM stage. It splits one
// VEC_LEN-lane op into single-lane memory beats with configurable stride, per-lane mask
// and memory wait states. It stalls the pipeline until the op completes and returns
// packed load data for WB.
// PARAMETERS
// LANE_W   32  bits per lane / memory word
// VEC_LEN  4   lanes per vector op (>=1)
// ADDR_W   32  byte-address width; all address arithmetic is modulo 2**ADDR_W
// PORTS
// clk        in   1               clock
// reset      in   1               asynchronous, active-high reset
// op_valid   in   1               op present; held stable with all op_* while stall=1
// op_vector  in   1               1=vector (VEC_LEN beats), 0=scalar (lane 0 only)
// op_store   in   1               1=store, 0=load
// op_base    in   ADDR_W          byte address of lane 0
// op_stride  in   ADDR_W          lane-to-lane byte stride (0 allowed: same word)
// op_mask    in   VEC_LEN         lane enable; scalar uses bit 0 only
// op_wdata   in   VEC_LEN*LANE_W  store data, lane i at [i*LANE_W +: LANE_W]
// stall      out  1               op in flight and not completing this cycle
// mem_req    out  1               beat request
// mem_we     out  1               beat is a write
// mem_addr   out  ADDR_W          op_base + i*op_stride
// mem_wdata  out  LANE_W          lane i of store data
// mem_rdata  in   LANE_W          read data, valid in the cycle mem_ready=1
// mem_ready  in   1               beat accepted this cycle (wait states when 0)
// rd_data    out  VEC_LEN*LANE_W  registered load result
// rd_valid   out  1               1-cycle pulse, the cycle after a load completes
// BEHAVIOUR
// - States IDLE, ACTIVE. Reset: IDLE, beat=0, rd_data=0, rd_valid=0, latched op regs=0.
// - Outputs mem_req/mem_we/stall are forced 0 asynchronously while reset=1.
// - IDLE with op_valid: accept the op. Beat 0 drives mem_* directly from op_* inputs
//   in the same cycle. All op fields are latched at the accept edge.
// - Beat i is done when mask[i]=0 (no mem_req, 1 cycle) or when mem_req & mem_ready.
// - Last beat is VEC_LEN-1 for a vector op and 0 for a scalar op.
// - Last beat done in IDLE: stay IDLE. This gives a 0-cycle stall for a ready scalar op.
// - Otherwise go to ACTIVE with beat = done ? 1 : 0.
// - ACTIVE: mem_* come from latched regs. Beat increments when done.
//   Last beat done -> IDLE.
// - mem_ready=0: hold mem_req, mem_addr, mem_wdata and mem_we stable. No upper bound
//   on wait states.
// - stall = op in flight & ~(last beat done this cycle). It is combinational from
//   mem_ready, with no bubble between back-to-back ops.
// - op_valid is ignored in ACTIVE; the upstream stage holds the op.
// - Load: the accept edge zeroes rd_data. Each done, unmasked beat writes lane i with
//   mem_rdata. Masked lanes read 0. Scalar gives {0, lane0}.
// - rd_data holds until the next load is accepted. Stores never change rd_data or
//   pulse rd_valid.
// - Address: beat 0 uses op_base. Each later beat adds op_stride via a running adder,
//   wrapping modulo 2**ADDR_W.
// - All-zero mask: VEC_LEN cycles, no mem_req. A load still pulses rd_valid with
//   rd_data=0.
// - VEC_LEN=1: the beat counter is 1 bit wide, tied 0.
// - Reset mid-op aborts the op: no rd_valid, and rd_data returns to 0.
// STRUCTURE
// - Package ldst_pkg: typedef enum logic {IDLE, ACTIVE} ldst_seq_state_e, and
//   localparam BEAT_W = (VEC_LEN>1) ? $clog2(VEC_LEN) : 1.
// - Single module, no sub-modules. Lane select uses the indexed part-select [i*LANE_W +: LANE_W].
// TESTING
// 1 Scalar load, base=0x100, mem_ready=1, rdata=0xDEADBEEF -> stall=0,
//   addr=0x100, next cycle rd_valid=1, rd_data=0x...0_DEADBEEF.
// 2 Vector load, base=0x200, stride=4, mask=4'hF, ready=1 -> addrs
//   0x200/204/208/20C, stall high 3 cycles, rd_data lanes = rdata seq, rd_valid once.
// 3 Vector store, stride=16, mask=4'b1010, wdata lanes A,B,C,D -> writes only B@base+16,
//   D@base+48; 4 cycles.
// 4 Vector load, ready low 2 cycles on beat 2 -> mem_addr/mem_req stable for 3
//   cycles, total stall 5 cycles.
// 5 base=0xFFFF_FFF8, stride=4 -> addrs FFF8, FFFC, 0x0, 0x4 (wrap).
// 6 Reset asserted mid beat 2 -> mem_req=0 immediately, rd_data=0, no rd_valid;
//   a new scalar op after release runs normally.

Source files
------------

// File: rtl/vector_ldst_sequencer_pkg.sv
// Package for the vector load/store sequencer: FSM state type and beat-counter
// width helper. The module sizes its own counter from its VEC_LEN parameter via
// beat_width(); BEAT_W below is that width for the default 4-lane configuration.
package ldst_pkg;

    typedef enum logic {IDLE, ACTIVE} ldst_seq_state_e;

    // A 1-lane unit still needs a 1-bit counter (tied to zero).
    function automatic int beat_width(input int vec_len);
        return (vec_len > 1) ? $clog2(vec_len) : 1;
    endfunction

    localparam int DEF_VEC_LEN = 4;
    localparam int BEAT_W      = beat_width(DEF_VEC_LEN);

endpackage

// File: rtl/vector_ldst_sequencer_if.sv
// Bus bundle for the sequencer: upstream op inputs, stall back to the pipeline,
// single-lane memory port, and packed load result towards WB.
//   slave  : the sequencer's view (consumes op_*, mem_rdata/mem_ready)
//   master : the environment's view (pipeline + memory)
interface vector_ldst_sequencer_if #(
    parameter int LANE_W  = 32,
    parameter int VEC_LEN = 4,
    parameter int ADDR_W  = 32
);
    logic                      op_valid;
    logic                      op_vector;
    logic                      op_store;
    logic [ADDR_W-1:0]         op_base;
    logic [ADDR_W-1:0]         op_stride;
    logic [VEC_LEN-1:0]        op_mask;
    logic [VEC_LEN*LANE_W-1:0] op_wdata;
    logic                      stall;
    logic                      mem_req;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [LANE_W-1:0]         mem_wdata;
    logic [LANE_W-1:0]         mem_rdata;
    logic                      mem_ready;
    logic [VEC_LEN*LANE_W-1:0] rd_data;
    logic                      rd_valid;

    modport slave (
        input  op_valid, op_vector, op_store, op_base, op_stride, op_mask, op_wdata,
        input  mem_rdata, mem_ready,
        output stall, mem_req, mem_we, mem_addr, mem_wdata, rd_data, rd_valid
    );

    modport master (
        output op_valid, op_vector, op_store, op_base, op_stride, op_mask, op_wdata,
        output mem_rdata, mem_ready,
        input  stall, mem_req, mem_we, mem_addr, mem_wdata, rd_data, rd_valid
    );
endinterface

// File: rtl/vector_ldst_sequencer.sv
// MEM-stage vector/scalar load-store sequencer. Splits one op into single-lane
// memory beats (stride, per-lane mask, memory wait states), stalls the pipeline
// until the last beat completes, and returns packed load data for WB.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave view of vector_ldst_sequencer_if (op_*, stall, mem_*, rd_*)
// Beat 0 is issued straight from the op inputs in the accept cycle, so a scalar
// op whose memory is ready costs no stall at all.
module vector_ldst_sequencer
    import ldst_pkg::*;
#(
    parameter int LANE_W  = 32,
    parameter int VEC_LEN = 4,
    parameter int ADDR_W  = 32
) (
    input logic                     clk,
    input logic                     reset,
    vector_ldst_sequencer_if.slave  bus
);

    localparam int               CNT_W     = beat_width(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

    ldst_seq_state_e state_q, state_d;

    logic [CNT_W-1:0]          beat_q;
    logic [ADDR_W-1:0]         addr_q;      // running address of the current beat
    logic [ADDR_W-1:0]         stride_q;
    logic                      vec_q;
    logic                      store_q;
    logic [VEC_LEN-1:0]        mask_q;
    logic [VEC_LEN*LANE_W-1:0] wdata_q;
    logic [VEC_LEN*LANE_W-1:0] rd_data_q;
    logic                      rd_valid_q;

    // Current-beat view: op inputs while IDLE (accept cycle), latched regs in ACTIVE.
    logic                      idle;
    logic                      in_flight;
    logic                      cur_vec;
    logic                      cur_store;
    logic [ADDR_W-1:0]         cur_addr;
    logic [ADDR_W-1:0]         cur_stride;
    logic [VEC_LEN-1:0]        cur_mask;
    logic [VEC_LEN*LANE_W-1:0] cur_wdata;
    logic [CNT_W-1:0]          cur_beat;
    logic [CNT_W-1:0]          beat_nxt;
    logic                      lane_en;
    logic                      beat_done;
    logic                      last_beat;
    logic                      op_done;

    always_comb begin
        idle       = (state_q == IDLE);
        in_flight  = idle ? bus.op_valid  : 1'b1;
        cur_vec    = idle ? bus.op_vector : vec_q;
        cur_store  = idle ? bus.op_store  : store_q;
        cur_addr   = idle ? bus.op_base   : addr_q;
        cur_stride = idle ? bus.op_stride : stride_q;
        cur_mask   = idle ? bus.op_mask   : mask_q;
        cur_wdata  = idle ? bus.op_wdata  : wdata_q;
        cur_beat   = idle ? '0            : beat_q;

        lane_en   = cur_mask[cur_beat];
        // Masked lanes retire in one cycle without touching memory.
        beat_done = in_flight & (~lane_en | bus.mem_ready);
        last_beat = cur_vec ? (cur_beat == LAST_BEAT) : (cur_beat == '0);
        op_done   = beat_done & last_beat;

        beat_nxt = cur_beat;
        if (VEC_LEN == 1 || op_done)
            beat_nxt = '0;
        else if (beat_done)
            beat_nxt = cur_beat + 1'b1;

        state_d = state_q;
        if (idle) begin
            if (bus.op_valid && !op_done)
                state_d = ACTIVE;
        end else if (op_done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q     <= '0;
            addr_q     <= '0;
            stride_q   <= '0;
            vec_q      <= 1'b0;
            store_q    <= 1'b0;
            mask_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= in_flight & ~cur_store & op_done;
            if (in_flight) begin
                beat_q <= beat_nxt;
                addr_q <= beat_done ? cur_addr + cur_stride : cur_addr;
            end
            if (idle && bus.op_valid) begin
                vec_q    <= bus.op_vector;
                store_q  <= bus.op_store;
                stride_q <= bus.op_stride;
                mask_q   <= bus.op_mask;
                wdata_q  <= bus.op_wdata;
            end
            if (in_flight && !cur_store) begin
                // Accept clears the result; the lane write below overrides its slice.
                if (idle)
                    rd_data_q <= '0;
                if (beat_done && lane_en)
                    rd_data_q[cur_beat*LANE_W +: LANE_W] <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req   = ~reset & in_flight & lane_en;
    assign bus.mem_we    = ~reset & in_flight & lane_en & cur_store;
    assign bus.stall     = ~reset & in_flight & ~op_done;
    assign bus.mem_addr  = cur_addr;
    assign bus.mem_wdata = cur_wdata[cur_beat*LANE_W +: LANE_W];
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_vector_ldst_sequencer.sv
// Directed bench for vector_ldst_sequencer (LANE_W=32, VEC_LEN=4, ADDR_W=32).
module tb_vector_ldst_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vector_ldst_sequencer_if #(.LANE_W(32), .VEC_LEN(4), .ADDR_W(32)) bus ();

    vector_ldst_sequencer #(.LANE_W(32), .VEC_LEN(4), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] rdata_tab [4];
    logic [31:0] req_addr[$];
    logic [31:0] req_wdata[$];
    logic        req_we[$];
    logic [31:0] cyc_addr[$];
    logic        cyc_req[$];
    int          stalls, cycles;
    logic [127:0] saved_rd;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one op, plays memory (ready low wait_n cycles on wait_beat),
    // logs every cycle, and returns at the cycle after completion.
    task automatic run_op(input logic vec, input logic st, input logic [31:0] base,
                          input logic [31:0] stride, input logic [3:0] mask,
                          input logic [127:0] wdata, input int wait_beat, input int wait_n);
        int  beat = 0;
        int  waits = 0;
        bit  done_flag = 0;
        req_addr.delete(); req_wdata.delete(); req_we.delete();
        cyc_addr.delete(); cyc_req.delete();
        stalls = 0; cycles = 0;
        bus.op_vector = vec; bus.op_store = st; bus.op_base = base;
        bus.op_stride = stride; bus.op_mask = mask; bus.op_wdata = wdata;
        bus.op_valid = 1'b1;
        while (!done_flag && cycles < 40) begin
            bus.mem_ready = (beat == wait_beat && waits < wait_n) ? 1'b0 : 1'b1;
            bus.mem_rdata = rdata_tab[beat < 4 ? beat : 0];
            #1;
            cyc_addr.push_back(bus.mem_addr);
            cyc_req.push_back(bus.mem_req);
            if (bus.mem_req && bus.mem_ready) begin
                req_addr.push_back(bus.mem_addr);
                req_wdata.push_back(bus.mem_wdata);
                req_we.push_back(bus.mem_we);
            end
            if (bus.stall) stalls++;
            else done_flag = 1;
            cycles++;
            if (!bus.mem_ready) waits++;
            else beat++;
            tick();
        end
        bus.op_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        chk("op_completes", done_flag, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        bus.op_valid = 0; bus.op_vector = 0; bus.op_store = 0; bus.op_base = 0;
        bus.op_stride = 0; bus.op_mask = 0; bus.op_wdata = 0;
        bus.mem_rdata = 0; bus.mem_ready = 1;
        #2;
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_rd_valid", bus.rd_valid, 1'b0);
        chk("rst_rd_data", bus.rd_data, 128'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // 1: scalar load, zero stall
        rdata_tab = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
        run_op(1'b0, 1'b0, 32'h100, 32'h4, 4'hF, 128'h0, -1, 0);
        chk("t1_stalls", stalls, 0);
        chk("t1_addr", req_addr[0], 32'h100);
        chk("t1_we", req_we[0], 1'b0);
        chk("t1_rd_valid", bus.rd_valid, 1'b1);
        chk("t1_rd_data", bus.rd_data, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
        tick();
        chk("t1_rd_valid_pulse", bus.rd_valid, 1'b0);

        // 2: vector load, stride 4, all lanes
        rdata_tab = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_op(1'b1, 1'b0, 32'h200, 32'h4, 4'hF, 128'h0, -1, 0);
        chk("t2_stalls", stalls, 3);
        chk("t2_nreq", req_addr.size(), 4);
        chk("t2_addr0", req_addr[0], 32'h200);
        chk("t2_addr1", req_addr[1], 32'h204);
        chk("t2_addr2", req_addr[2], 32'h208);
        chk("t2_addr3", req_addr[3], 32'h20C);
        chk("t2_rd_valid", bus.rd_valid, 1'b1);
        chk("t2_rd_data", bus.rd_data, 128'h44444444_33333333_22222222_11111111);
        saved_rd = 128'h44444444_33333333_22222222_11111111;
        tick();
        chk("t2_rd_valid_pulse", bus.rd_valid, 1'b0);

        // 3: masked vector store, stride 16
        run_op(1'b1, 1'b1, 32'h1000, 32'h10, 4'b1010,
               128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001, -1, 0);
        chk("t3_cycles", cycles, 4);
        chk("t3_nreq", req_addr.size(), 2);
        chk("t3_addr0", req_addr[0], 32'h1010);
        chk("t3_data0", req_wdata[0], 32'hBBBB0002);
        chk("t3_we0", req_we[0], 1'b1);
        chk("t3_addr1", req_addr[1], 32'h1030);
        chk("t3_data1", req_wdata[1], 32'hDDDD0004);
        chk("t3_rd_valid", bus.rd_valid, 1'b0);
        chk("t3_rd_kept", bus.rd_data, saved_rd);

        // 4: wait states on beat 2
        rdata_tab = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003};
        run_op(1'b1, 1'b0, 32'h300, 32'h8, 4'hF, 128'h0, 2, 2);
        chk("t4_stalls", stalls, 5);
        chk("t4_cycles", cycles, 6);
        for (int i = 2; i <= 4; i++) begin
            chk("t4_hold_req", cyc_req[i], 1'b1);
            chk("t4_hold_addr", cyc_addr[i], 32'h310);
        end
        chk("t4_addr_last", cyc_addr[5], 32'h318);
        chk("t4_rd_data", bus.rd_data, 128'hA0000003_A0000002_A0000001_A0000000);

        // 5: address wrap
        rdata_tab = '{32'h1, 32'h2, 32'h3, 32'h4};
        run_op(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h4, 4'hF, 128'h0, -1, 0);
        chk("t5_addr0", req_addr[0], 32'hFFFF_FFF8);
        chk("t5_addr1", req_addr[1], 32'hFFFF_FFFC);
        chk("t5_addr2", req_addr[2], 32'h0);
        chk("t5_addr3", req_addr[3], 32'h4);

        // partial mask load: masked lanes read 0
        rdata_tab = '{32'h5, 32'h22222222, 32'h33333333, 32'h6};
        run_op(1'b1, 1'b0, 32'h500, 32'h4, 4'b0110, 128'h0, -1, 0);
        chk("pm_nreq", req_addr.size(), 2);
        chk("pm_rd_data", bus.rd_data, 128'h00000000_33333333_22222222_00000000);

        // all-zero mask load
        run_op(1'b1, 1'b0, 32'h600, 32'h4, 4'h0, 128'h0, -1, 0);
        chk("zm_cycles", cycles, 4);
        chk("zm_nreq", req_addr.size(), 0);
        chk("zm_rd_valid", bus.rd_valid, 1'b1);
        chk("zm_rd_data", bus.rd_data, 128'h0);

        // 6: reset in the middle of beat 2
        tick();
        rdata_tab = '{32'h12345678, 32'h0, 32'h0, 32'h0};
        bus.op_vector = 1; bus.op_store = 0; bus.op_base = 32'h700; bus.op_stride = 32'h4;
        bus.op_mask = 4'hF; bus.op_valid = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h77777777;
        tick();
        tick();
        bus.mem_ready = 0;
        #1;
        chk("t6_req_b2", bus.mem_req, 1'b1);
        chk("t6_addr_b2", bus.mem_addr, 32'h708);
        reset = 1'b1;
        #1;
        chk("t6_rst_req", bus.mem_req, 1'b0);
        chk("t6_rst_stall", bus.stall, 1'b0);
        chk("t6_rst_rd_data", bus.rd_data, 128'h0);
        bus.op_valid = 0;
        tick();
        chk("t6_rst_rd_valid", bus.rd_valid, 1'b0);
        reset = 1'b0;
        bus.mem_ready = 1;
        tick();
        chk("t6_post_rd_valid", bus.rd_valid, 1'b0);
        run_op(1'b0, 1'b0, 32'h40, 32'h0, 4'h1, 128'h0, -1, 0);
        chk("t6_scalar_stalls", stalls, 0);
        chk("t6_scalar_addr", req_addr[0], 32'h40);
        chk("t6_scalar_rd_valid", bus.rd_valid, 1'b1);
        chk("t6_scalar_rd_data", bus.rd_data, 128'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
